mem_io_ctrl: RTL
================

# mem_io_ctrl

Memory/IO access sequencer for the LC-3 datapath. On a request from the control unit, it decodes the latched MAR address and runs either an external memory transaction (request/ready handshake with timeout) or a single-cycle device-register access (KBSR/KBDR/DSR/DDR). It drives the MIOMUX value and the MDR load for reads, and the device-register load strobes for writes. It returns a one-cycle ready pulse (R) to the control unit.

## Interface
Parameters:
- TIMEOUT_CYC, 16: maximum cycles MEM_WAIT holds a request without MEM_READY before aborting.
- KBSR_ADDR, 16'hFE00: keyboard status register address.
- KBDR_ADDR, 16'hFE02: keyboard data register address.
- DSR_ADDR, 16'hFE04: display status register address.
- DDR_ADDR, 16'hFE06: display data register address.

Ports:
- i_Clk  in  1  clock; all state changes on its rising edge.
- i_Rst  in  1  reset, synchronous, active-high.
- MEM_EN  in  1  access request from the control unit; sampled only in IDLE.
- R_W  in  1  1 = write, 0 = read; sampled with MEM_EN.
- MAR_OUT  in  16  access address.
- MDR_OUT  in  16  write data.
- MEM_RDATA  in  16  external memory read data.
- MEM_READY  in  1  external memory completion.
- KBSR_OUT, KBDR_OUT, DSR_OUT  in  16 each  device register contents.
- MEM_REQ  out  1  external memory request.
- MEM_WE  out  1  external memory write enable; valid while MEM_REQ is high.
- MEM_ADDR  out  16  latched address.
- MEM_WDATA  out  16  latched write data.
- MIOMUX_OUT  out  16  data to MDR.
- LD_MDR  out  1  MDR load strobe.
- LD_KBSR, LD_DSR, LD_DDR  out  1 each  device write strobes.
- KBDR_RD  out  1  pulses on a KBDR read; external logic clears KBSR[15].
- R  out  1  access-complete pulse.
- MEM_ERR  out  1  timeout pulse.

## Operation
- States: IDLE, MEM_WAIT, DEV, DONE.
- **IDLE**
  - MEM_EN=1 latches MAR_OUT into MEM_ADDR, MDR_OUT into MEM_WDATA, and R_W.
  - Address in xFE00–xFFFF goes to DEV; otherwise goes to MEM_WAIT.
  - MEM_EN=0 holds IDLE.
- **MEM_WAIT**
  - MEM_REQ=1; MEM_WE equals the latched R_W. Address and data stay stable for the whole state.
  - Wait counter clears on entry and increments each cycle.
  - MEM_READY=1:
    - Read: MIOMUX_OUT=MEM_RDATA and LD_MDR=1 in that same cycle.
    - Then go to DONE.
  - Counter reaches TIMEOUT_CYC-1 with MEM_READY=0:
    - MEM_ERR=1.
    - Read: MIOMUX_OUT=16'h0000 and LD_MDR=1.
    - Then go to DONE.
  - MEM_READY wins if it coincides with timeout.
- **DEV** (exactly one cycle, then DONE)
  - Read: MIOMUX_OUT is the selected register and LD_MDR=1.
    - KBDR read also asserts KBDR_RD=1.
    - Unmapped device address reads 16'h0000.
  - Write: assert the matching strobe among LD_KBSR, LD_DSR, LD_DDR.
    - Writes to KBDR or unmapped addresses are ignored: no strobe.
- **DONE**
  - R=1 for one cycle, then IDLE.
  - If MEM_EN is still high in the following IDLE cycle, a new access starts. The control unit must drop MEM_EN on seeing R.
- MIOMUX_OUT is 16'h0000 whenever LD_MDR=0.
- All strobes are single-cycle and mutually exclusive.

## Timing
- Reset values:
  - State is IDLE; counter is 0.
  - MEM_ADDR and MEM_WDATA are 16'h0000.
  - All 1-bit outputs are 0; MIOMUX_OUT is 16'h0000.
- i_Rst at any point, including mid-MEM_WAIT, forces IDLE at that edge:
  - MEM_REQ drops the next cycle.
  - No R, MEM_ERR, LD_MDR or device strobe is emitted.
- Device access, with MEM_EN sampled at edge 0:
  - DEV strobes are in cycle 1; R is in cycle 2.
  - Total 3 cycles, request to R.
- Memory access:
  - MEM_REQ is asserted from cycle 1.
  - If MEM_READY is seen in cycle k, LD_MDR is in cycle k and R is in cycle k+1.
  - With MEM_READY held high, minimum latency is 3 cycles.
- Timeout: MEM_ERR is in cycle TIMEOUT_CYC (cycle 16 with the default); R follows the next cycle.
- MEM_READY outside MEM_WAIT is ignored.
- MAR_OUT and MDR_OUT changes after the latch edge have no effect.

## Structure
- Shared package lc3_mem_pkg:
  - Device address constants.
  - State enum {IDLE, MEM_WAIT, DEV, DONE}.
  - Width constant WORD_W=16.
- One sub-module, io_addr_decode (combinational): address in; is_dev, sel_kbsr, sel_kbdr, sel_dsr, sel_ddr out.
- Timeout counter width is clog2(TIMEOUT_CYC).

## Test plan
- Read x3000, MEM_READY high 2 cycles after MEM_REQ, MEM_RDATA=16'h1234 -> MIOMUX_OUT=16'h1234 with LD_MDR, R one cycle later, MEM_WE=0 throughout.
- Write xFE06 with MDR_OUT=16'h0041 -> LD_DDR one cycle after the request; MEM_REQ never asserted; R the following cycle.
- Read xFE02 with KBDR_OUT=16'h0061 -> LD_MDR, MIOMUX_OUT=16'h0061 and KBDR_RD all in the same cycle; read xFE10 -> MIOMUX_OUT=16'h0000.
- Read x4000 with MEM_READY never asserted -> MEM_ERR in cycle 16, LD_MDR with 16'h0000, R in cycle 17.
- Assert i_Rst mid-MEM_WAIT (cycle 3) -> next cycle MEM_REQ=0, no R; a new request after reset completes normally.
- MEM_EN held high across DONE -> back-to-back accesses, each with exactly one R; MEM_READY asserted while in IDLE -> ignored.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// rtl/lc3_mem_pkg.sv - shared types and constants for the LC-3 memory/IO sequencer
package lc3_mem_pkg;

   localparam int          WORD_W        = 16;
   localparam logic [15:0] DEV_BASE      = 16'hFE00;
   localparam logic [15:0] KBSR_ADDR_DEF = 16'hFE00;
   localparam logic [15:0] KBDR_ADDR_DEF = 16'hFE02;
   localparam logic [15:0] DSR_ADDR_DEF  = 16'hFE04;
   localparam logic [15:0] DDR_ADDR_DEF  = 16'hFE06;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      DEV      = 2'd2,
      DONE     = 2'd3
   } state_t;

endpackage

// File: rtl/mem_io_ctrl_addr_decode.sv
// rtl/mem_io_ctrl_addr_decode.sv - device-page detect and device register selects
module io_addr_decode
   import lc3_mem_pkg::*;
#(
   parameter logic [15:0] KBSR_ADDR = KBSR_ADDR_DEF,
   parameter logic [15:0] KBDR_ADDR = KBDR_ADDR_DEF,
   parameter logic [15:0] DSR_ADDR  = DSR_ADDR_DEF,
   parameter logic [15:0] DDR_ADDR  = DDR_ADDR_DEF
) (
   input  logic [WORD_W-1:0] addr,
   output logic              is_dev,
   output logic              sel_kbsr,
   output logic              sel_kbdr,
   output logic              sel_dsr,
   output logic              sel_ddr
);

   // Everything from xFE00 up is the device page, mapped register or not.
   assign is_dev   = (addr >= DEV_BASE);
   assign sel_kbsr = (addr == KBSR_ADDR);
   assign sel_kbdr = (addr == KBDR_ADDR);
   assign sel_dsr  = (addr == DSR_ADDR);
   assign sel_ddr  = (addr == DDR_ADDR);

endmodule

// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - LC-3 memory/IO access sequencer with memory timeout
module mem_io_ctrl
   import lc3_mem_pkg::*;
#(
   parameter int          TIMEOUT_CYC = 16,
   parameter logic [15:0] KBSR_ADDR   = 16'hFE00,
   parameter logic [15:0] KBDR_ADDR   = 16'hFE02,
   parameter logic [15:0] DSR_ADDR    = 16'hFE04,
   parameter logic [15:0] DDR_ADDR    = 16'hFE06
) (
   input  logic              i_Clk,
   input  logic              i_Rst,
   input  logic              MEM_EN,
   input  logic              R_W,
   input  logic [WORD_W-1:0] MAR_OUT,
   input  logic [WORD_W-1:0] MDR_OUT,
   input  logic [WORD_W-1:0] MEM_RDATA,
   input  logic              MEM_READY,
   input  logic [WORD_W-1:0] KBSR_OUT,
   input  logic [WORD_W-1:0] KBDR_OUT,
   input  logic [WORD_W-1:0] DSR_OUT,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [WORD_W-1:0] MEM_ADDR,
   output logic [WORD_W-1:0] MEM_WDATA,
   output logic [WORD_W-1:0] MIOMUX_OUT,
   output logic              LD_MDR,
   output logic              LD_KBSR,
   output logic              LD_DSR,
   output logic              LD_DDR,
   output logic              KBDR_RD,
   output logic              R,
   output logic              MEM_ERR
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;

   logic              dec_is_dev, dec_kbsr, dec_kbdr, dec_dsr, dec_ddr;
   logic              mem_req, ld_mdr, ld_kbsr, ld_dsr, ld_ddr, kbdr_rd, r_pulse, mem_err;
   logic [WORD_W-1:0] miomux;

   // Decoding the next address lets one decoder serve both the IDLE branch and DEV.
   assign addr_d = (state_q == IDLE && MEM_EN) ? MAR_OUT : addr_q;

   io_addr_decode #(
      .KBSR_ADDR (KBSR_ADDR),
      .KBDR_ADDR (KBDR_ADDR),
      .DSR_ADDR  (DSR_ADDR),
      .DDR_ADDR  (DDR_ADDR)
   ) u_decode (
      .addr     (addr_d),
      .is_dev   (dec_is_dev),
      .sel_kbsr (dec_kbsr),
      .sel_kbdr (dec_kbdr),
      .sel_dsr  (dec_dsr),
      .sel_ddr  (dec_ddr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      mem_req = 1'b0;
      ld_mdr  = 1'b0;
      miomux  = '0;
      ld_kbsr = 1'b0;
      ld_dsr  = 1'b0;
      ld_ddr  = 1'b0;
      kbdr_rd = 1'b0;
      r_pulse = 1'b0;
      mem_err = 1'b0;
      case (state_q)
         IDLE: begin
            if (MEM_EN) begin
               wdata_d = MDR_OUT;
               we_d    = R_W;
               cnt_d   = '0;
               state_d = dec_is_dev ? DEV : MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            mem_req = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
            if (MEM_READY) begin
               ld_mdr  = ~we_q;
               miomux  = we_q ? '0 : MEM_RDATA;
               state_d = DONE;
            end else if (cnt_q == CNT_LAST) begin
               mem_err = 1'b1;
               ld_mdr  = ~we_q;
               state_d = DONE;
            end
         end
         DEV: begin
            state_d = DONE;
            if (!we_q) begin
               ld_mdr  = 1'b1;
               kbdr_rd = dec_kbdr;
               if (dec_kbsr)      miomux = KBSR_OUT;
               else if (dec_kbdr) miomux = KBDR_OUT;
               else if (dec_dsr)  miomux = DSR_OUT;
            end else begin
               ld_kbsr = dec_kbsr;
               ld_dsr  = dec_dsr;
               ld_ddr  = dec_ddr;
            end
         end
         DONE: begin
            r_pulse = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
      end
   end

   // Completion strobes are suppressed during the reset cycle so an aborted access leaves no trace.
   assign MEM_REQ    = mem_req;
   assign MEM_WE     = mem_req & we_q;
   assign MEM_ADDR   = addr_q;
   assign MEM_WDATA  = wdata_q;
   assign LD_MDR     = ld_mdr  & ~i_Rst;
   assign MIOMUX_OUT = (ld_mdr & ~i_Rst) ? miomux : '0;
   assign LD_KBSR    = ld_kbsr & ~i_Rst;
   assign LD_DSR     = ld_dsr  & ~i_Rst;
   assign LD_DDR     = ld_ddr  & ~i_Rst;
   assign KBDR_RD    = kbdr_rd & ~i_Rst;
   assign R          = r_pulse & ~i_Rst;
   assign MEM_ERR    = mem_err & ~i_Rst;

endmodule
